// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch queue.
//   fetch_entry_t : one queued fetch result {instr, pc, pc_plus4}
//   FETCH_DEPTH   : default queue depth
//   XLEN          : instruction / address width
package fetch_pkg;

    localparam int FETCH_DEPTH = 4;
    localparam int XLEN        = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the PC-stage, instruction-memory and decode
// signals around the fetch queue.
//   master : PC stage / memory / decode side (drives PC, PCPlus4, Instr,
//            Redirect, ReadyD; observes FetchStall and the head entry)
//   slave  : the fetch queue itself
interface fetch_queue_if #(
    parameter int XLEN  = fetch_pkg::XLEN,
    parameter int DEPTH = fetch_pkg::FETCH_DEPTH
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] Instr;
    logic            Redirect;
    logic            FetchStall;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            ReadyD;
    logic [CW-1:0]   Count;

    modport master (
        output PC, PCPlus4, Instr, Redirect, ReadyD,
        input  FetchStall, InstrD, PCD, PCPlus4D, ValidD, Count
    );

    modport slave (
        input  PC, PCPlus4, Instr, Redirect, ReadyD,
        output FetchStall, InstrD, PCD, PCPlus4D, ValidD, Count
    );

endinterface : fetch_queue_if

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
//   CLK, Reset : clock and asynchronous active-high reset
//   push       : write push_data at the tail this edge
//   pop        : advance the head this edge
//   flush      : empty the FIFO this edge; overrides push and pop
//   count      : number of stored entries
//   head       : head entry, all-zero while empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;
    logic [DEPTH-1:0] wr_en;
    fetch_entry_t  slot [DEPTH];

    // Upstream credit accounting keeps push off a full FIFO; the full guard
    // here only protects stored data if that contract is ever broken.
    assign do_push = push & ~flush & (count_reg != CW'(DEPTH));
    assign do_pop  = pop  & ~flush & (count_reg != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            assign wr_en[gi] = do_push & (tail_reg == AW'(gi));

            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    entry_reg <= '0;
                end else if (wr_en[gi]) begin
                    entry_reg <= push_data;
                end
            end

            assign slot[gi] = entry_reg;
        end
    endgenerate

    // Pointers are AW bits wide, so DEPTH being a power of two makes the
    // increment wrap modulo DEPTH for free.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (do_pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = (count_reg != '0) ? slot[head_reg] : '0;

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch buffer between the PC stage and decode.
// A fetch address is captured in a request register; the synchronous
// instruction memory returns its word one cycle later, and the triple
// {Instr, PC, PC+4} is pushed into a FIFO that decode drains under a
// ValidD/ReadyD handshake. FetchStall backpressures the PC stage and a
// Redirect discards all queued and in-flight work.
//   CLK, Reset : clock and asynchronous active-high reset
//   fq (slave) : PC, PCPlus4, Instr, Redirect, ReadyD in;
//                FetchStall, InstrD, PCD, PCPlus4D, ValidD, Count out
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = fetch_pkg::FETCH_DEPTH,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input logic          CLK,
    input logic          Reset,
    fetch_queue_if.slave fq
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            req_valid_reg;
    logic [XLEN-1:0] req_pc_reg;
    logic [XLEN-1:0] req_pc4_reg;

    logic            stall;
    logic            valid;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Request register: remembers which address the memory is currently
    // reading so its data can be paired with it on the next edge. A stalled
    // or redirected cycle issues no request.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            req_valid_reg <= 1'b0;
            req_pc_reg    <= '0;
            req_pc4_reg   <= '0;
        end else begin
            req_valid_reg <= ~stall & ~fq.Redirect;
            req_pc_reg    <= fq.PC;
            req_pc4_reg   <= fq.PCPlus4;
        end
    end

    // Credit check counts the in-flight request as occupied and ignores a
    // same-cycle pop, so every issued request is guaranteed a free slot and
    // ReadyD never reaches FetchStall combinationally.
    assign occupancy = {1'b0, count} + (CW + 1)'(req_valid_reg);
    assign stall     = occupancy >= (CW + 1)'(DEPTH);

    assign valid = (count != '0) & ~fq.Redirect;
    assign pop   = valid & fq.ReadyD;
    assign push  = req_valid_reg & ~fq.Redirect;

    assign push_data = '{instr: fq.Instr, pc: req_pc_reg, pc_plus4: req_pc4_reg};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (fq.Redirect),
        .count     (count),
        .head      (head)
    );

    assign fq.FetchStall = stall;
    assign fq.ValidD     = valid;
    assign fq.Count      = count;
    assign fq.InstrD     = head.instr;
    assign fq.PCD        = head.pc;
    assign fq.PCPlus4D   = head.pc_plus4;

endmodule : fetch_queue
